// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, oversampling constants and baud codes
// for the UART receive and transmit paths.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2,
        WAIT_IDLE
    } uart_rx_state_e;

    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK   = 7;
    localparam int MIN_FRAME  = 5;
    localparam int MAX_FRAME  = 8;

    localparam logic [1:0] BAUD_9600  = 2'b00;
    localparam logic [1:0] BAUD_19200 = 2'b01;
    localparam logic [1:0] BAUD_38400 = 2'b10;
    localparam logic [1:0] BAUD_FAST  = 2'b11;

    localparam logic [9:0] DIV0 = 10'd651;
    localparam logic [9:0] DIV1 = 10'd326;
    localparam logic [9:0] DIV2 = 10'd163;
    localparam logic [9:0] DIV3 = 10'd16;

    // Index of the last data bit, with the length clamped to 5..8.
    function automatic logic [2:0] last_bit_idx(input logic [3:0] len);
        if (len < 4'(MIN_FRAME)) begin
            return 3'(MIN_FRAME - 1);
        end else if (len > 4'(MAX_FRAME)) begin
            return 3'(MAX_FRAME - 1);
        end else begin
            return 3'(len - 4'd1);
        end
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: divisor select plus 16x oversampling tick counter.
// restart clears the counter so the tick phase aligns to a start edge.
module uart_baud_gen
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] baud,
    input  logic       restart,
    output logic       tick
);

    logic [9:0] div;
    logic [9:0] cnt_q;
    logic [9:0] cnt_d;
    logic       wrap;

    always_comb begin
        div = DIV3;
        unique case (baud)
            BAUD_9600:  div = DIV0;
            BAUD_19200: div = DIV1;
            BAUD_38400: div = DIV2;
            BAUD_FAST:  div = DIV3;
        endcase
    end

    // >= keeps the counter sane if the divisor shrinks while it runs.
    always_comb begin
        wrap  = (cnt_q >= div - 10'd1);
        tick  = wrap & ~restart;
        cnt_d = (wrap | restart) ? 10'd0 : cnt_q + 10'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: 16x oversampled UART receiver with parity/stop checking.
// Define UART_RX_MAJORITY_EN for 3-sample majority voting per bit.
module uart_rx_core
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic [1:0] baud,
    input  logic [3:0] frame_length,
    input  logic       parity_en,
    input  logic       parity_type,
    input  logic       stop2,
    output logic [7:0] rx_data_out,
    output logic       rx_done,
    output logic       correct,
    output logic       parity_err,
    output logic       frame_err,
    output logic       break_det,
    output logic       busy
);

    localparam int TW = $clog2(OVERSAMPLE);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [TW-1:0] SAMPLE_TICK = TW'(MID_TICK + 1);
`else
    localparam logic [TW-1:0] SAMPLE_TICK = TW'(MID_TICK);
`endif

    uart_rx_state_e state_q, state_d;
    logic          rx_s1_q, rx_s2_q, rx_prev_q;
    logic          fall, tick, restart, samp, bit_val;
    logic          ferr_v, finish;
    logic [1:0]    baud_q, baud_d, baud_sel;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d, last_q, last_d;
    logic [7:0]    shift_q, shift_d, data_q, data_d;
    logic          par_en_q, par_en_d, par_odd_q, par_odd_d;
    logic          stop2_q, stop2_d, hi_q, hi_d;
    logic          perr_q, perr_d, ferr_q, ferr_d, pbit_q, pbit_d;
    logic          done_q, done_d, ok_q, ok_d, brk_q, brk_d;
    logic          perr_o_q, perr_o_d, ferr_o_q, ferr_o_d;
    logic          busy_q, busy_d;

    assign fall     = rx_prev_q & ~rx_s2_q;
    assign samp     = tick & (tick_cnt_q == SAMPLE_TICK);
    assign baud_sel = (state_q == IDLE) ? baud : baud_q;

    uart_baud_gen u_baud (
        .clk     (clk),
        .reset   (reset),
        .baud    (baud_sel),
        .restart (restart),
        .tick    (tick)
    );

`ifdef UART_RX_MAJORITY_EN
    logic s6_q, s6_d, s7_q, s7_d;

    always_comb begin
        s6_d = s6_q;
        s7_d = s7_q;
        if (tick && tick_cnt_q == TW'(MID_TICK - 1)) s6_d = rx_s2_q;
        if (tick && tick_cnt_q == TW'(MID_TICK)) s7_d = rx_s2_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s6_q <= 1'b0;
            s7_q <= 1'b0;
        end else begin
            s6_q <= s6_d;
            s7_q <= s7_d;
        end
    end

    assign bit_val = (s6_q & s7_q) | (rx_s2_q & (s6_q | s7_q));
`else
    assign bit_val = rx_s2_q;
`endif

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        tick_cnt_d = tick ? tick_cnt_q + 1'b1 : tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        last_d     = last_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        stop2_d    = stop2_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        pbit_d     = pbit_q;
        hi_d       = hi_q;
        data_d     = data_q;
        ok_d       = ok_q;
        perr_o_d   = perr_o_q;
        ferr_o_d   = ferr_o_q;
        brk_d      = brk_q;
        done_d     = 1'b0;
        restart    = 1'b0;
        finish     = 1'b0;
        ferr_v     = ferr_q | ~bit_val;

        unique case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d    = START;
                    restart    = 1'b1;
                    tick_cnt_d = '0;
                    baud_d     = baud;
                    last_d     = last_bit_idx(frame_length);
                    par_en_d   = parity_en;
                    par_odd_d  = parity_type;
                    stop2_d    = stop2;
                    shift_d    = '0;
                    perr_d     = 1'b0;
                    ferr_d     = 1'b0;
                    pbit_d     = 1'b0;
                end
            end
            START: begin
                if (samp) begin
                    state_d   = bit_val ? IDLE : DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (samp) begin
                    shift_d[bit_cnt_q] = bit_val;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == last_q) begin
                        state_d = par_en_q ? PARITY : STOP1;
                    end
                end
            end
            PARITY: begin
                if (samp) begin
                    pbit_d  = bit_val;
                    perr_d  = bit_val ^ (^shift_q) ^ par_odd_q;
                    state_d = STOP1;
                end
            end
            STOP1: begin
                if (samp) begin
                    ferr_d = ferr_v;
                    if (stop2_q) state_d = STOP2;
                    else finish = 1'b1;
                end
            end
            STOP2: begin
                if (samp) finish = 1'b1;
            end
            WAIT_IDLE: begin
                // Line must stay high across a whole tick interval.
                if (!rx_s2_q) begin
                    hi_d = 1'b0;
                end else if (tick) begin
                    if (hi_q) state_d = IDLE;
                    else hi_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (finish) begin
            done_d   = 1'b1;
            ferr_d   = ferr_v;
            data_d   = shift_q;
            perr_o_d = perr_q;
            ferr_o_d = ferr_v;
            ok_d     = ~perr_q & ~ferr_v;
            brk_d    = ferr_v & ~(|shift_q) & ~pbit_q;
            hi_d     = 1'b0;
            state_d  = bit_val ? IDLE : WAIT_IDLE;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            state_q    <= IDLE;
            baud_q     <= '0;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            last_q     <= '0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            stop2_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            pbit_q     <= 1'b0;
            hi_q       <= 1'b0;
            data_q     <= '0;
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
            perr_o_q   <= 1'b0;
            ferr_o_q   <= 1'b0;
            brk_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            rx_s1_q    <= rx;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            state_q    <= state_d;
            baud_q     <= baud_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            last_q     <= last_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            stop2_q    <= stop2_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            pbit_q     <= pbit_d;
            hi_q       <= hi_d;
            data_q     <= data_d;
            done_q     <= done_d;
            ok_q       <= ok_d;
            perr_o_q   <= perr_o_d;
            ferr_o_q   <= ferr_o_d;
            brk_q      <= brk_d;
            busy_q     <= busy_d;
        end
    end

    assign rx_data_out = data_q;
    assign rx_done     = done_q;
    assign correct     = ok_q;
    assign parity_err  = perr_o_q;
    assign frame_err   = ferr_o_q;
    assign break_det   = brk_q;
    assign busy        = busy_q;

endmodule
